// File: rtl/stacker_core.sv
// stacker_core: block-stacking game core for the stacker LED display.
// A block of lit columns bounces across the active row on move ticks and is
// locked onto the stack by a drop pulse. Win/lose states drive a flash strobe.
// Optional feature macro: STACKER_TRIM_EN (trim misaligned columns instead of
// losing outright on any misalignment).
module stacker_core #(
  parameter int COLS        = 8,
  parameter int ROWS        = 8,
  parameter int START_WIDTH = 3,
  parameter int BASE_PERIOD = 8,
  parameter int FLASH_TICKS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tick,
  input  logic                       drop,
  input  logic [$clog2(ROWS)-1:0]    rd_row,
  output logic [COLS-1:0]            rd_data,
  output logic [$clog2(ROWS+1)-1:0]  level,
  output logic [$clog2(COLS+1)-1:0]  width,
  output logic [1:0]                 state,
  output logic                       flash
);

  localparam int RW = $clog2(ROWS);
  localparam int LW = $clog2(ROWS + 1);
  localparam int WW = $clog2(COLS + 1);

  localparam logic [WW-1:0] START_W = WW'(START_WIDTH);

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    WIN  = 2'd1,
    LOSE = 2'd2
  } state_t;

  typedef enum logic {
    RIGHT = 1'b0,
    LEFT  = 1'b1
  } dir_t;

  // width ones packed against the MSB end of the row
  function automatic logic [COLS-1:0] msb_ones(input logic [WW-1:0] w);
    logic [COLS-1:0] r;
    r = '0;
    for (int i = 0; i < COLS; i++) begin
      if (i < int'(w)) r[COLS-1-i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [WW-1:0] popcount(input logic [COLS-1:0] v);
    logic [WW-1:0] c;
    c = '0;
    for (int i = 0; i < COLS; i++) c = c + WW'(v[i]);
    return c;
  endfunction

  state_t          st, st_n;
  dir_t            dir, dir_n;
  logic [COLS-1:0] block, block_n;
  logic [LW-1:0]   level_n;
  logic [WW-1:0]   width_n;
  logic [7:0]      step_cnt, step_cnt_n;
  logic [7:0]      flash_cnt, flash_cnt_n;
  logic            flash_n;
  logic [COLS-1:0] rows [ROWS];
  logic            row_we, clear_rows;
  logic [COLS-1:0] row_wdata;

  logic [LW-1:0]   level_m1;
  logic [COLS-1:0] below, keep, stepped, rd_next;
  logic [WW-1:0]   width_next;
  logic [8:0]      diff;
  logic [7:0]      period_m1;
  dir_t            dir_stepped;

  assign state = st;

  // Row under the active row, the columns that survive a drop, and the
  // width the next block will have.
  always_comb begin
    level_m1 = level - LW'(1);
    below    = (level == '0) ? '0 : rows[level_m1[RW-1:0]];
`ifdef STACKER_TRIM_EN
    keep       = (level == '0) ? block : (block & below);
    width_next = popcount(keep);
`else
    keep       = ((level == '0) || (block == below)) ? block : '0;
    width_next = width;
`endif
  end

  // Step period shrinks with level; 9-bit difference exposes underflow in bit 8.
  always_comb begin
    diff      = 9'(BASE_PERIOD) - 9'(level);
    period_m1 = (diff[8] || (diff == 9'd0)) ? 8'd0 : 8'(diff - 9'd1);
  end

  // One bounce step: shift in the current direction, reversing at an edge.
  always_comb begin
    stepped     = block;
    dir_stepped = dir;
    if (dir == RIGHT) begin
      if (block[0]) begin
        dir_stepped = LEFT;
        stepped     = block << 1;
      end else begin
        stepped     = block >> 1;
      end
    end else begin
      if (block[COLS-1]) begin
        dir_stepped = RIGHT;
        stepped     = block >> 1;
      end else begin
        stepped     = block << 1;
      end
    end
  end

  // Next-state and game logic; drop takes priority over tick in every state.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    st_n        = st;
    dir_n       = dir;
    block_n     = block;
    level_n     = level;
    width_n     = width;
    step_cnt_n  = step_cnt;
    flash_cnt_n = flash_cnt;
    flash_n     = flash;
    row_we      = 1'b0;
    row_wdata   = '0;
    clear_rows  = 1'b0;
    case (st)
      PLAY: begin
        if (drop) begin
          step_cnt_n = 8'd0;
          if (keep == '0) begin
            st_n        = LOSE;
            flash_cnt_n = 8'd0;
            flash_n     = 1'b0;
          end else begin
            row_we    = 1'b1;
            row_wdata = keep;
            width_n   = width_next;
            level_n   = level + LW'(1);
            if (level_n == LW'(ROWS)) begin
              st_n        = WIN;
              flash_cnt_n = 8'd0;
              flash_n     = 1'b0;
            end else begin
              block_n = msb_ones(width_next);
              dir_n   = RIGHT;
            end
          end
        end else if (tick) begin
          if (step_cnt == period_m1) begin
            step_cnt_n = 8'd0;
            if (width != WW'(COLS)) begin
              block_n = stepped;
              dir_n   = dir_stepped;
            end
          end else begin
            step_cnt_n = step_cnt + 8'd1;
          end
        end
      end
      WIN, LOSE: begin
        if (drop) begin
          st_n        = PLAY;
          block_n     = msb_ones(START_W);
          dir_n       = RIGHT;
          level_n     = '0;
          width_n     = START_W;
          step_cnt_n  = 8'd0;
          flash_cnt_n = 8'd0;
          flash_n     = 1'b0;
          clear_rows  = 1'b1;
        end else if (tick) begin
          if (flash_cnt == 8'(FLASH_TICKS - 1)) begin
            flash_cnt_n = 8'd0;
            flash_n     = ~flash;
          end else begin
            flash_cnt_n = flash_cnt + 8'd1;
          end
        end
      end
      default: st_n = PLAY;
    endcase
  end

  // Readout mux: active block overlays its row only while playing.
  always_comb begin
    rd_next = '0;
    if (int'(rd_row) >= ROWS) begin
      rd_next = '0;
    end else if ((st == PLAY) && (LW'(rd_row) == level)) begin
      rd_next = block;
    end else if ((st == PLAY) && (LW'(rd_row) > level)) begin
      rd_next = '0;
    end else begin
      rd_next = rows[rd_row];
    end
  end

  // Game state registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= PLAY;
      dir       <= RIGHT;
      block     <= msb_ones(START_W);
      level     <= '0;
      width     <= START_W;
      step_cnt  <= 8'd0;
      flash_cnt <= 8'd0;
      flash     <= 1'b0;
      rd_data   <= '0;
    end else begin
      st        <= st_n;
      dir       <= dir_n;
      block     <= block_n;
      level     <= level_n;
      width     <= width_n;
      step_cnt  <= step_cnt_n;
      flash_cnt <= flash_cnt_n;
      flash     <= flash_n;
      rd_data   <= rd_next;
    end
  end

  // Stack rows: cleared on reset and on restart, written on a successful drop.
  // NOTE: the row array is reset like ordinary registers because the display
  // reads it directly and a restart must show an empty stack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ROWS; i++) rows[i] <= '0;
    end else if (clear_rows) begin
      for (int i = 0; i < ROWS; i++) rows[i] <= '0;
    end else if (row_we) begin
      rows[level[RW-1:0]] <= row_wdata;
    end
  end

endmodule

// File: tb/tb_stacker_core.sv
// tb_stacker_core: directed self-checking bench for stacker_core.
// Three instances: main (BASE_PERIOD=8, ROWS=8), fast (BASE_PERIOD=1) for the
// bounce sequence, and tall (ROWS=16) to reach level 8 where every tick steps.
module tb_stacker_core;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // main instance
  logic       tick = 1'b0, drop = 1'b0;
  logic [2:0] rd_row = '0;
  logic [7:0] rd_data;
  logic [3:0] level;
  logic [3:0] width;
  logic [1:0] state;
  logic       flash;

  // fast instance
  logic       tick_f = 1'b0, drop_f = 1'b0;
  logic [2:0] rd_row_f = '0;
  logic [7:0] rd_data_f;
  logic [3:0] level_f;
  logic [3:0] width_f;
  logic [1:0] state_f;
  logic       flash_f;

  // tall instance
  logic       tick_t = 1'b0, drop_t = 1'b0;
  logic [3:0] rd_row_t = '0;
  logic [7:0] rd_data_t;
  logic [4:0] level_t;
  logic [3:0] width_t;
  logic [1:0] state_t;
  logic       flash_t;

  stacker_core #(.COLS(8), .ROWS(8), .START_WIDTH(3), .BASE_PERIOD(8), .FLASH_TICKS(4)) u_main (
    .clk(clk), .reset(reset), .tick(tick), .drop(drop), .rd_row(rd_row),
    .rd_data(rd_data), .level(level), .width(width), .state(state), .flash(flash)
  );

  stacker_core #(.COLS(8), .ROWS(8), .START_WIDTH(3), .BASE_PERIOD(1), .FLASH_TICKS(4)) u_fast (
    .clk(clk), .reset(reset), .tick(tick_f), .drop(drop_f), .rd_row(rd_row_f),
    .rd_data(rd_data_f), .level(level_f), .width(width_f), .state(state_f), .flash(flash_f)
  );

  stacker_core #(.COLS(8), .ROWS(16), .START_WIDTH(3), .BASE_PERIOD(8), .FLASH_TICKS(4)) u_tall (
    .clk(clk), .reset(reset), .tick(tick_t), .drop(drop_t), .rd_row(rd_row_t),
    .rd_data(rd_data_t), .level(level_t), .width(width_t), .state(state_t), .flash(flash_t)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
    end
  endtask

  task automatic read_main(input logic [2:0] r);
    rd_row = r;
    cycle();
  endtask

  initial begin
    logic [7:0] bounce [12];
    int lose_level;
    bounce = '{8'hE0, 8'h70, 8'h38, 8'h1C, 8'h0E, 8'h07,
               8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'h70};

    // reset values while reset is held
    #12;
    check("reset_state", state, 0);
    check("reset_level", level, 0);
    check("reset_width", width, 3);
    check("reset_flash", flash, 0);
    check("reset_rd_data", rd_data, 0);
    reset = 1'b1;
    cycle();

    // bounce sequence with a step on every tick
    check("bounce_0", rd_data_f, bounce[0]);
    for (int i = 1; i < 12; i++) begin
      tick_f = 1'b1;
      cycle();
      tick_f = 1'b0;
      cycle();
      check($sformatf("bounce_%0d", i), rd_data_f, bounce[i]);
    end

    // tall: eight back-to-back drops, then period clamps to 1
    drop_t = 1'b1;
    repeat (8) cycle();
    drop_t = 1'b0;
    check("tall_level8", level_t, 8);
    check("tall_state", state_t, 0);
    rd_row_t = 4'd8;
    cycle();
    check("tall_block", rd_data_t, 8'hE0);
    tick_t = 1'b1; cycle(); tick_t = 1'b0; cycle();
    check("tall_step1", rd_data_t, 8'h70);
    tick_t = 1'b1; cycle(); tick_t = 1'b0; cycle();
    check("tall_step2", rd_data_t, 8'h38);

    // main: initial readout
    read_main(3'd0);
    check("main_block0", rd_data, 8'hE0);
    read_main(3'd1);
    check("main_row1_empty", rd_data, 8'h00);

    // lock level 0 at E0
    drop = 1'b1; cycle(); drop = 1'b0;
    check("drop0_level", level, 1);
    check("drop0_width", width, 3);
    check("drop0_state", state, 0);
    read_main(3'd0);
    check("drop0_row0", rd_data, 8'hE0);

    // level 1: period 7; drop on the 7th (stepping) tick uses the old block
    ticks(6);
    read_main(3'd1);
    check("lvl1_no_step", rd_data, 8'hE0);
    tick = 1'b1; drop = 1'b1; cycle(); tick = 1'b0; drop = 1'b0;
    check("coinc_level", level, 2);
    check("coinc_width", width, 3);
    read_main(3'd1);
    check("coinc_row1", rd_data, 8'hE0);

    // level 3: period 5
    drop = 1'b1; cycle(); drop = 1'b0;
    check("drop2_level", level, 3);
    ticks(4);
    read_main(3'd3);
    check("lvl3_no_step", rd_data, 8'hE0);
    ticks(1);
    cycle();
    check("lvl3_step", rd_data, 8'h70);

    // drop 70 onto E0
    drop = 1'b1; cycle(); drop = 1'b0;
`ifdef STACKER_TRIM_EN
    check("trim_level", level, 4);
    check("trim_width", width, 2);
    check("trim_state", state, 0);
    read_main(3'd3);
    check("trim_row3", rd_data, 8'h60);
    read_main(3'd4);
    check("trim_new_block", rd_data, 8'hC0);
    ticks(24);
    cycle();
    check("trim_block_03", rd_data, 8'h03);
    drop = 1'b1; cycle(); drop = 1'b0;
    check("trim_lose_state", state, 2);
    check("trim_lose_level", level, 4);
    lose_level = 4;
`else
    check("notrim_lose_state", state, 2);
    check("notrim_lose_level", level, 3);
    check("notrim_lose_width", width, 3);
    lose_level = 3;
`endif

    // LOSE shows the stack only
    read_main(3'(lose_level));
    check("lose_stack_only", rd_data, 8'h00);
    read_main(3'd2);
    check("lose_row2", rd_data, 8'hE0);

    // flash in LOSE, then tick+drop restarts with flash cleared
    ticks(3);
    check("lose_flash_3", flash, 0);
    ticks(1);
    check("lose_flash_4", flash, 1);
    ticks(3);
    check("lose_flash_7", flash, 1);
    tick = 1'b1; drop = 1'b1; cycle(); tick = 1'b0; drop = 1'b0;
    check("restart_flash", flash, 0);
    check("restart_state", state, 0);
    check("restart_level", level, 0);
    check("restart_width", width, 3);
    read_main(3'd1);
    check("restart_row1", rd_data, 8'h00);
    read_main(3'd0);
    check("restart_block", rd_data, 8'hE0);

    // perfect stack: eight back-to-back drops
    drop = 1'b1;
    repeat (8) cycle();
    drop = 1'b0;
    check("win_state", state, 1);
    check("win_level", level, 8);
    check("win_width", width, 3);
    for (int r = 0; r < 8; r++) begin
      read_main(3'(r));
      check($sformatf("win_row%0d", r), rd_data, 8'hE0);
    end
    check("win_flash_0", flash, 0);
    ticks(3);
    check("win_flash_3", flash, 0);
    ticks(1);
    check("win_flash_4", flash, 1);
    ticks(4);
    check("win_flash_8", flash, 0);

    // restart, play a little, then reset mid-game
    drop = 1'b1; cycle(); drop = 1'b0;
    check("win_restart_state", state, 0);
    drop = 1'b1; cycle(); drop = 1'b0;
    ticks(7);
    read_main(3'd1);
    check("mid_block", rd_data, 8'h70);
    #2 reset = 1'b0;
    #1;
    check("async_level", level, 0);
    check("async_state", state, 0);
    check("async_rd_data", rd_data, 0);
    #3 reset = 1'b1;
    for (int r = 0; r < 8; r++) begin
      read_main(3'(r));
      check($sformatf("post_reset_row%0d", r), rd_data, (r == 0) ? 8'hE0 : 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
